// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage load/store port.
// Accepts one word request, services it LATENCY cycles later and stalls the pipeline meanwhile.
module dmem_responder #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              stall,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]        LAT_M1  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              stateNext_s;
    logic [3:0]          cnt_r;
    logic [3:0]          cntNext_s;
    logic                commit_s;

    logic                reqWrite_r;
    logic [ADDR_W-1:0]   reqAddr_r;
    logic [DATA_W-1:0]   reqWdata_r;

    logic                cmtWrite_s;
    logic [ADDR_W-1:0]   cmtAddr_s;
    logic [DATA_W-1:0]   cmtWdata_s;
    logic                inRange_s;
    logic [IDX_W-1:0]    idx_s;

    logic                respValid_r;
    logic [DATA_W-1:0]   respRdata_r;
    logic                respErr_r;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Zero-extended compare so addresses at or above DEPTH never alias into the array.
    function automatic logic addrInRange(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < DEPTH_L);
    endfunction

    // State and wait-counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= stateNext_s;
            cnt_r   <= cntNext_s;
        end
    end

    // Next-state, counter and commit decode.
    always_comb begin
        stateNext_s = state_r;
        cntNext_s   = cnt_r;
        commit_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        stateNext_s = DONE;
                        commit_s    = 1'b1;
                    end else begin
                        stateNext_s = WAIT;
                        cntNext_s   = LAT_M1;
                    end
                end else begin
                    stateNext_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd1) begin
                    stateNext_s = DONE;
                    commit_s    = 1'b1;
                end else begin
                    cntNext_s   = cnt_r - 4'd1;
                end
            end
            DONE: begin
                stateNext_s = IDLE;
            end
            default: begin
                stateNext_s = IDLE;
                cntNext_s   = 4'd0;
            end
        endcase
    end

    // Capture the request on the acceptance edge; later changes on req_* are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reqWrite_r <= 1'b0;
            reqAddr_r  <= '0;
            reqWdata_r <= '0;
        end else if (state_r == IDLE && req_valid) begin
            reqWrite_r <= req_write;
            reqAddr_r  <= req_addr;
            reqWdata_r <= req_wdata;
        end else begin
            reqWrite_r <= reqWrite_r;
            reqAddr_r  <= reqAddr_r;
            reqWdata_r <= reqWdata_r;
        end
    end

    // With LATENCY==1 the commit happens on the acceptance edge itself, so use live inputs.
    always_comb begin
        if (state_r == IDLE) begin
            cmtWrite_s = req_write;
            cmtAddr_s  = req_addr;
            cmtWdata_s = req_wdata;
        end else begin
            cmtWrite_s = reqWrite_r;
            cmtAddr_s  = reqAddr_r;
            cmtWdata_s = reqWdata_r;
        end
        inRange_s = addrInRange(cmtAddr_s);
        idx_s     = cmtAddr_s[IDX_W-1:0];
    end

    // Array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (!rst && commit_s && cmtWrite_s && inRange_s) begin
            mem[idx_s] <= cmtWdata_s;
        end
    end

    // Response registers: strobe, load data and range error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            respValid_r <= 1'b0;
            respRdata_r <= '0;
            respErr_r   <= 1'b0;
        end else begin
            respValid_r <= (stateNext_s == DONE);
            if (commit_s) begin
                respErr_r <= ~inRange_s;
                if (!cmtWrite_s) begin
                    respRdata_r <= inRange_s ? mem[idx_s] : '0;
                end else begin
                    respRdata_r <= respRdata_r;
                end
            end else begin
                respErr_r   <= respErr_r;
                respRdata_r <= respRdata_r;
            end
        end
    end

    assign req_ready  = (state_r == IDLE);
    assign stall      = ((state_r == IDLE) && req_valid) || (state_r == WAIT);
    assign resp_valid = respValid_r;
    assign resp_rdata = respRdata_r;
    assign resp_err   = respErr_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three builds (LATENCY 2, 1, 15) with a response scoreboard.
`timescale 1ns/1ps
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reqValid  [3];
    logic        reqWrite  [3];
    logic [15:0] reqAddr   [3];
    logic [31:0] reqWdata  [3];
    logic        reqReady  [3];
    logic        stall     [3];
    logic        respValid [3];
    logic [31:0] respRdata [3];
    logic        respErr   [3];

    typedef struct {
        int          k;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mdl[int];
    logic [31:0] lastRd[3];
    int          nTests = 0;
    int          nFail  = 0;

    always #5 clk = ~clk;

    dmem_responder #(.LATENCY(2)) dut0 (
        .clk(clk), .rst(rst), .req_valid(reqValid[0]), .req_write(reqWrite[0]),
        .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]), .req_ready(reqReady[0]),
        .stall(stall[0]), .resp_valid(respValid[0]), .resp_rdata(respRdata[0]), .resp_err(respErr[0]));
    dmem_responder #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(reqValid[1]), .req_write(reqWrite[1]),
        .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]), .req_ready(reqReady[1]),
        .stall(stall[1]), .resp_valid(respValid[1]), .resp_rdata(respRdata[1]), .resp_err(respErr[1]));
    dmem_responder #(.LATENCY(15)) dut15 (
        .clk(clk), .rst(rst), .req_valid(reqValid[2]), .req_write(reqWrite[2]),
        .req_addr(reqAddr[2]), .req_wdata(reqWdata[2]), .req_ready(reqReady[2]),
        .stall(stall[2]), .resp_valid(respValid[2]), .resp_rdata(respRdata[2]), .resp_err(respErr[2]));

    function automatic int latOf(input int k);
        case (k)
            0: return 2;
            1: return 1;
            default: return 15;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request on instance k, check stall/ready/valid each cycle, pop the scoreboard on response.
    task automatic txn(input int k, input logic wr, input logic [15:0] addr,
                       input logic [31:0] wd, input bit hold);
        int   lat = latOf(k);
        int   key = k * 65536 + int'(addr);
        logic inRange = (addr < 16'd1024);
        exp_t e;
        exp_t got;
        if (wr) begin
            if (inRange) mdl[key] = wd;
            e.rdata = lastRd[k];
        end else begin
            e.rdata   = inRange ? mdl[key] : 32'h0;
            lastRd[k] = e.rdata;
        end
        e.k   = k;
        e.err = ~inRange;
        sbq.push_back(e);
        reqValid[k] = 1'b1;
        reqWrite[k] = wr;
        reqAddr[k]  = addr;
        reqWdata[k] = wd;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            chk($sformatf("stall k%0d c%0d", k, c), 32'(stall[k]), 32'(c < lat));
            chk($sformatf("ready k%0d c%0d", k, c), 32'(reqReady[k]), 32'(c == 0));
            chk($sformatf("valid k%0d c%0d", k, c), 32'(respValid[k]), 32'(c == lat));
            if (respValid[k]) begin
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 32'(sbq.size()), 32'd1);
                end else begin
                    got = sbq.pop_front();
                    chk($sformatf("rdata k%0d a%h", k, addr), respRdata[k], got.rdata);
                    chk($sformatf("err k%0d a%h", k, addr), 32'(respErr[k]), 32'(got.err));
                end
            end
            @(posedge clk);
            #1;
            if (hold) begin
                reqWrite[k] = 1'($urandom_range(0, 1));
                reqAddr[k]  = 16'($urandom_range(0, 2047));
                reqWdata[k] = $urandom;
            end else begin
                reqValid[k] = 1'b0;
            end
        end
    endtask

    task automatic checkIdleAll();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_ready k%0d", k), 32'(reqReady[k]), 32'd1);
            chk($sformatf("rst_stall k%0d", k), 32'(stall[k]), 32'd0);
            chk($sformatf("rst_valid k%0d", k), 32'(respValid[k]), 32'd0);
            chk($sformatf("rst_rdata k%0d", k), respRdata[k], 32'h0);
            chk($sformatf("rst_err k%0d", k), 32'(respErr[k]), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            reqValid[k] = 1'b0;
            reqWrite[k] = 1'b0;
            reqAddr[k]  = 16'h0;
            reqWdata[k] = 32'h0;
            lastRd[k]   = 32'h0;
        end
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        // Async reset asserted mid-cycle after some activity.
        txn(0, 1'b1, 16'd9, 32'h0BAD_F00D, 1'b0);
        #2 rst = 1'b1;
        #1 checkIdleAll();
        lastRd[0] = 32'h0;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Store then load, back to back.
        txn(0, 1'b1, 16'd5, 32'hDEAD_BEEF, 1'b0);
        txn(0, 1'b0, 16'd5, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rdata_hold", respRdata[0], 32'hDEAD_BEEF);
        @(posedge clk);
        #1;

        // Out-of-range accesses must not alias onto word 0.
        txn(0, 1'b1, 16'h0000, 32'hCAFE_0000, 1'b0);
        txn(0, 1'b1, 16'h0400, 32'h1234_5678, 1'b0);
        txn(0, 1'b0, 16'h0400, 32'h0, 1'b0);
        txn(0, 1'b0, 16'h0000, 32'h0, 1'b0);
        txn(0, 1'b0, 16'hFFFF, 32'h0, 1'b0);

        // req_valid held with changing inputs: one transaction per accepted request.
        txn(0, 1'b1, 16'd20, 32'h5A5A_0001, 1'b1);
        txn(0, 1'b1, 16'd21, 32'h5A5A_0002, 1'b1);
        txn(0, 1'b0, 16'd20, 32'h0, 1'b1);
        txn(0, 1'b0, 16'd21, 32'h0, 1'b0);
        txn(0, 1'b0, 16'd5, 32'h0, 1'b0);

        // Reset during WAIT aborts an uncommitted store.
        txn(0, 1'b1, 16'd7, 32'h1111_1111, 1'b0);
        reqValid[0] = 1'b1;
        reqWrite[0] = 1'b1;
        reqAddr[0]  = 16'd7;
        reqWdata[0] = 32'hAAAA_5555;
        @(posedge clk);
        #1 reqValid[0] = 1'b0;
        chk("wait_stall", 32'(stall[0]), 32'd1);
        #1 rst = 1'b1;
        #1 checkIdleAll();
        for (int k = 0; k < 3; k++) lastRd[k] = 32'h0;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        txn(0, 1'b0, 16'd7, 32'h0, 1'b0);

        // Latency extremes.
        txn(1, 1'b1, 16'd3, 32'h3333_0001, 1'b0);
        txn(1, 1'b0, 16'd3, 32'h0, 1'b0);
        txn(1, 1'b0, 16'h0400, 32'h0, 1'b0);
        txn(2, 1'b1, 16'd3, 32'h3333_000F, 1'b0);
        txn(2, 1'b0, 16'd3, 32'h0, 1'b0);
        txn(2, 1'b1, 16'd1023, 32'h7777_8888, 1'b0);
        txn(2, 1'b0, 16'd1023, 32'h0, 1'b0);

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
